aes_spi_sequencer: RTL and testbench
====================================

// Module: aes_spi_sequencer
// PURPOSE
// - Host-side controller for the AES-256 encryption and decryption serial units.
// - Accepts one {mode, key, block} request and selects the target unit (enc or dec) with its chip select.
// - Shifts the key, then the block, onto mosi; waits for that unit's data_done; shifts the result back in from its miso.
// - Returns the result to the host through a valid/ready response port. One transaction is in flight at a time.
// PARAMETERS
// - NK           8     key length in 32-bit words; key phase = 32*NK bits
// - NB           4     block length in 32-bit words; message/result phase = 32*NB bits
// - TIMEOUT_CYC  1024  WAIT_DONE watchdog limit in clk cycles (used only with AES_SEQ_TIMEOUT_EN)
// PORTS
// - clk        in   1        system clock; the AES units run on the same clk
// - rst        in   1        asynchronous, active-low reset
// - req_valid  in   1        host request valid
// - req_ready  out  1        sequencer can accept a request (IDLE only)
// - req_mode   in   1        0 = encrypt (enc unit), 1 = decrypt (dec unit)
// - req_key    in   32*NK    key, shifted MSB first
// - req_data   in   32*NB    plaintext/ciphertext, shifted MSB first
// - rsp_valid  out  1        response valid
// - rsp_ready  in   1        host accepts response
// - rsp_data   out  32*NB    result block
// - rsp_err    out  1        1 = watchdog expired, rsp_data is all zero
// - busy       out  1        1 in any state other than IDLE
// - mosi       out  1        serial data to both units (shared line)
// - cs_enc_n   out  1        active-low select, encryption unit
// - cs_dec_n   out  1        active-low select, decryption unit
// - miso_enc   in   1        serial result from encryption unit
// - miso_dec   in   1        serial result from decryption unit
// - done_enc   in   1        data_done from encryption unit
// - done_dec   in   1        data_done from decryption unit
// BEHAVIOUR
// - Reset values: req_ready=1, rsp_valid=0, rsp_err=0, rsp_data=0, busy=0, mosi=0, cs_enc_n=1, cs_dec_n=1. State = IDLE.
// - Reset mid-transaction: abort immediately; the units see their chip selects deassert.
// - FSM states: IDLE -> LOAD_KEY -> LOAD_MSG -> WAIT_DONE -> READ -> RESP -> IDLE.
// - IDLE: req_ready=1. On req_valid&&req_ready, register mode, key and data and go to LOAD_KEY.
// - Accepted request, next cycle: the selected cs_*_n drives 0 and mosi drives key[MSB]. The other cs_*_n stays 1 for the whole transaction.
// - LOAD_KEY: one bit per clk, 32*NK cycles, MSB first.
// - LOAD_MSG: follows the last key bit with no gap; 32*NB cycles, MSB first.
// - WAIT_DONE: mosi=0 and cs stays low. Leave on the first cycle the selected done_* is sampled high; go to READ.
// - READ: on each of the next 32*NB clks, sample the selected miso_* and shift it in at the LSB. The first bit sampled ends up as rsp_data[MSB].
// - RESP: cs_*_n=1, rsp_valid=1, rsp_data/rsp_err held stable until rsp_ready. On rsp_valid&&rsp_ready go to IDLE.
// - IDLE re-entry: req_ready=1 in the cycle after the response handshake. There is no back-to-back bypass.
// - Bit counter width: $clog2(32*NK+1). It clears on every state change and never wraps inside a phase.
// - done_* outside WAIT_DONE is ignored. The done_* of the unselected unit is always ignored.
// - req_valid while busy is not accepted; req_* inputs are don't-care until IDLE.
// - Latency (NK=8, NB=4), request handshake to rsp_valid: 256+128+W+128+1 cycles, where W = cycles spent in WAIT_DONE.
// CONFIGURATION
// - AES_SEQ_TIMEOUT_EN defined:
//   - WAIT_DONE runs a cycle counter from 0.
//   - If TIMEOUT_CYC cycles pass with no done, go directly to RESP with rsp_err=1 and rsp_data=0.
//   - Chip select deasserts in RESP as normal.
// - AES_SEQ_TIMEOUT_EN undefined:
//   - No counter; WAIT_DONE waits indefinitely.
//   - rsp_err is tied to 0; TIMEOUT_CYC is unused.
// TESTING
// - Reset behaviour: drive rst=0 during LOAD_MSG -> cs_enc_n=cs_dec_n=1, busy=0, req_ready=1 within the same cycle. A new request then completes normally.
// - Encrypt: mode=0, key=000102..1e1f, data=00112233445566778899aabbccddeeff.
//   - cs_enc_n low for 384 shift cycles; cs_dec_n stays 1.
//   - rsp_data=8ea2b7ca516745bfeafc49904b496089, rsp_err=0.
// - Decrypt: mode=1, same key, data=8ea2b7ca516745bfeafc49904b496089.
//   - rsp_data=00112233445566778899aabbccddeeff; cs_dec_n low, cs_enc_n stays 1.
// - Backpressure: hold rsp_ready=0 for 50 cycles in RESP.
//   - rsp_valid and rsp_data stay stable; req_ready=0; a pulsed req_valid is not accepted.
// - Spurious done: pulse done_enc during LOAD_KEY, and done_dec during an encrypt's WAIT_DONE.
//   - Both are ignored; the FSM stays in WAIT_DONE until done_enc.
// - Timeout (macro on, TIMEOUT_CYC=16): never assert done.
//   - After 16 WAIT_DONE cycles: rsp_valid=1, rsp_err=1, rsp_data=0.
//   - With the macro off, the FSM is still in WAIT_DONE after 10000 cycles.

Source files
------------

// File: rtl/aes_spi_sequencer.sv
// aes_spi_sequencer: host-side controller for the AES-256 enc/dec serial units.
// Takes one {mode, key, block} request, selects the enc or dec unit, shifts the
// key then the block onto mosi, waits for the unit's done, shifts the result
// back in from miso and returns it on a valid/ready response port.
//
// Ports:
//   clk, rst               clock, asynchronous active-low reset
//   req_valid/req_ready    request handshake (ready only while idle)
//   req_mode               0 = encrypt (enc unit), 1 = decrypt (dec unit)
//   req_key, req_data      key (32*NK) and block (32*NB), shifted MSB first
//   rsp_valid/rsp_ready    response handshake
//   rsp_data, rsp_err      result block; err = watchdog expired (data zero)
//   busy                   high in every state other than idle
//   mosi                   shared serial data line to both units
//   cs_enc_n, cs_dec_n     active-low unit selects
//   miso_enc, miso_dec     serial results from the units
//   done_enc, done_dec     data_done strobes from the units
//
// Build option: define AES_SEQ_TIMEOUT_EN to enable the WAIT_DONE watchdog
// (TIMEOUT_CYC cycles). Without it the sequencer waits for done forever and
// rsp_err is tied low.

module aes_spi_sequencer #(
   parameter int NK          = 8,
   parameter int NB          = 4,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_mode,
   input  logic [32*NK-1:0] req_key,
   input  logic [32*NB-1:0] req_data,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [32*NB-1:0] rsp_data,
   output logic             rsp_err,
   output logic             busy,
   output logic             mosi,
   output logic             cs_enc_n,
   output logic             cs_dec_n,
   input  logic             miso_enc,
   input  logic             miso_dec,
   input  logic             done_enc,
   input  logic             done_dec
);

   localparam int KW = 32 * NK;
   localparam int BW = 32 * NB;
   localparam int CW = $clog2(KW + 1);

   // The shared bit counter is sized for the key phase; the block phases
   // must fit inside it.
   if (NB > NK) begin : g_bad_nb
      $error("NB must not exceed NK");
   end
   if (TIMEOUT_CYC < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYC must be at least 1");
   end

   typedef enum logic [2:0] {
      IDLE,
      LOAD_KEY,
      LOAD_MSG,
      WAIT_DONE,
      READ,
      RESP
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [CW-1:0]   cnt;
   logic            mode_r;
   logic [KW-1:0]   key_r;
   logic [BW-1:0]   data_r;
   logic            sel_done;
   logic            sel_miso;
   logic            last_key;
   logic            last_blk;
   logic            active;

   assign sel_done = mode_r ? done_dec : done_enc;
   assign sel_miso = mode_r ? miso_dec : miso_enc;
   assign last_key = (cnt == CW'(KW - 1));
   assign last_blk = (cnt == CW'(BW - 1));

`ifdef AES_SEQ_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   logic [TW-1:0] tcnt;
   logic          tmo;
   logic          err_r;

   assign tmo = (tcnt == TW'(TIMEOUT_CYC - 1));
`endif

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (req_valid) state_nxt = LOAD_KEY;
         end
         LOAD_KEY: begin
            if (last_key) state_nxt = LOAD_MSG;
         end
         LOAD_MSG: begin
            if (last_blk) state_nxt = WAIT_DONE;
         end
         WAIT_DONE: begin
            if (sel_done) begin
               state_nxt = READ;
            end
`ifdef AES_SEQ_TIMEOUT_EN
            else if (tmo) begin
               state_nxt = RESP;
            end
`endif
         end
         READ: begin
            if (last_blk) state_nxt = RESP;
         end
         RESP: begin
            if (rsp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath: one shift register per phase; the block register is reused
   // to collect the result, since it is fully shifted out (zero-filled)
   // by the time READ starts.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt    <= '0;
         mode_r <= 1'b0;
         key_r  <= '0;
         data_r <= '0;
      end else begin
         if (state_nxt != state) begin
            cnt <= '0;
         end else if (state == LOAD_KEY || state == LOAD_MSG ||
                      state == READ) begin
            cnt <= cnt + CW'(1);
         end

         unique case (state)
            IDLE: begin
               if (req_valid) begin
                  mode_r <= req_mode;
                  key_r  <= req_key;
                  data_r <= req_data;
               end
            end
            LOAD_KEY: key_r  <= key_r << 1;
            LOAD_MSG: data_r <= data_r << 1;
            READ:     data_r <= {data_r[BW-2:0], sel_miso};
            default: ;
         endcase

`ifdef AES_SEQ_TIMEOUT_EN
         if (state == WAIT_DONE && !sel_done && tmo) begin
            data_r <= '0;
         end
`endif
      end
   end

`ifdef AES_SEQ_TIMEOUT_EN
   // Watchdog: counts WAIT_DONE cycles; a done in the same cycle as the
   // expiry wins.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tcnt  <= '0;
         err_r <= 1'b0;
      end else begin
         if (state == WAIT_DONE) begin
            tcnt <= tcnt + TW'(1);
         end else begin
            tcnt <= '0;
         end

         if (state == IDLE) begin
            err_r <= 1'b0;
         end else if (state == WAIT_DONE && !sel_done && tmo) begin
            err_r <= 1'b1;
         end
      end
   end
`endif

   // Output logic
   always_comb begin
      active    = (state == LOAD_KEY) || (state == LOAD_MSG) ||
                  (state == WAIT_DONE) || (state == READ);
      req_ready = (state == IDLE);
      busy      = (state != IDLE);
      rsp_valid = (state == RESP);
      cs_enc_n  = !(active && !mode_r);
      cs_dec_n  = !(active && mode_r);
      mosi      = 1'b0;
      rsp_data  = '0;
      rsp_err   = 1'b0;

      unique case (state)
         LOAD_KEY: mosi = key_r[KW-1];
         LOAD_MSG: mosi = data_r[BW-1];
         RESP: begin
            rsp_data = data_r;
`ifdef AES_SEQ_TIMEOUT_EN
            rsp_err  = err_r;
`endif
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_aes_spi_sequencer.sv
// tb_aes_spi_sequencer: self-checking bench for aes_spi_sequencer.
// Emulates the selected AES unit on the serial side and checks the host side.

module tb_aes_spi_sequencer;

   localparam int NK = 8;
   localparam int NB = 4;
   localparam int TO = 16;

   localparam logic [255:0] KAT_KEY =
      256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] KAT_PT = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] KAT_CT = 128'h8ea2b7ca516745bfeafc49904b496089;

   logic         clk;
   logic         rst;
   logic         req_valid;
   logic         req_ready;
   logic         req_mode;
   logic [255:0] req_key;
   logic [127:0] req_data;
   logic         rsp_valid;
   logic         rsp_ready;
   logic [127:0] rsp_data;
   logic         rsp_err;
   logic         busy;
   logic         mosi;
   logic         cs_enc_n;
   logic         cs_dec_n;
   logic         miso_enc;
   logic         miso_dec;
   logic         done_enc;
   logic         done_dec;

   int n_cmp = 0;
   int n_bad = 0;

   // Observations collected by run_txn
   logic         obs_rdy_pre;
   logic [383:0] obs_rx;
   int           obs_cs_bad;
   int           obs_wait_bad;
   int           obs_hold_bad;
   logic         obs_valid;
   logic [127:0] obs_data;
   logic         obs_err;
   logic [1:0]   obs_cs_resp;
   logic [4:0]   obs_post;

   aes_spi_sequencer #(
      .NK(NK),
      .NB(NB),
      .TIMEOUT_CYC(TO)
   ) dut (
      .clk(clk),
      .rst(rst),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_mode(req_mode),
      .req_key(req_key),
      .req_data(req_data),
      .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready),
      .rsp_data(rsp_data),
      .rsp_err(rsp_err),
      .busy(busy),
      .mosi(mosi),
      .cs_enc_n(cs_enc_n),
      .cs_dec_n(cs_dec_n),
      .miso_enc(miso_enc),
      .miso_dec(miso_dec),
      .done_enc(done_enc),
      .done_dec(done_dec)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stand-in for the AES units: FIPS-197 AES-256 vectors answer exactly,
   // anything else gets a cheap keyed transform (the sequencer only moves
   // bits, so any invertible-looking function exposes shifting errors).
   function automatic logic [127:0] unit_fn(input bit dec,
                                            input logic [255:0] k,
                                            input logic [127:0] d);
      if (k == KAT_KEY && !dec && d == KAT_PT) return KAT_CT;
      if (k == KAT_KEY && dec && d == KAT_CT) return KAT_PT;
      return {d[126:0], d[127]} ^ k[255:128] ^ k[127:0] ^ {128{dec}};
   endfunction

   function automatic logic [255:0] rand_key();
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
      return r;
   endfunction

   function automatic logic [127:0] rand_blk();
      logic [127:0] r;
      for (int i = 0; i < 4; i++) r[32*i +: 32] = $urandom;
      return r;
   endfunction

   // One full transaction: host request, unit emulation, response with
   // optional backpressure. Records what was observed in obs_*.
   task automatic run_txn(input bit mode, input logic [255:0] key,
                          input logic [127:0] data, input int wcyc,
                          input bit spur, input int bp);
      logic [383:0] rx;
      logic [127:0] res;
      bit           dec_u;
      rx = '0;
      obs_cs_bad = 0;
      obs_wait_bad = 0;
      obs_hold_bad = 0;
      @(negedge clk);
      obs_rdy_pre = req_ready;
      req_valid = 1'b1;
      req_mode  = mode;
      req_key   = key;
      req_data  = data;
      @(negedge clk);
      req_valid = 1'b0;
      req_mode  = ~mode;
      req_key   = rand_key();
      req_data  = rand_blk();
      dec_u = (cs_dec_n === 1'b0);
      for (int k = 0; k < 384; k++) begin
         if (k > 0) @(negedge clk);
         rx = {rx[382:0], mosi};
         if (cs_enc_n !== mode || cs_dec_n !== ~mode ||
             busy !== 1'b1 || req_ready !== 1'b0) obs_cs_bad++;
         if (dec_u) done_dec = spur && k == 10;
         else       done_enc = spur && k == 10;
      end
      done_enc = 1'b0;
      done_dec = 1'b0;
      obs_rx = rx;
      res = unit_fn(dec_u, rx[383:128], rx[127:0]);
      for (int w = 1; w < wcyc; w++) begin
         @(negedge clk);
         if (cs_enc_n !== mode || cs_dec_n !== ~mode || busy !== 1'b1 ||
             rsp_valid !== 1'b0 || mosi !== 1'b0) obs_wait_bad++;
         if (dec_u) done_enc = spur && w == 1;
         else       done_dec = spur && w == 1;
      end
      @(negedge clk);
      done_enc = 1'b0;
      done_dec = 1'b0;
      if (cs_enc_n !== mode || rsp_valid !== 1'b0 || mosi !== 1'b0)
         obs_wait_bad++;
      if (dec_u) done_dec = 1'b1;
      else       done_enc = 1'b1;
      for (int j = 0; j < 128; j++) begin
         @(negedge clk);
         done_enc = 1'b0;
         done_dec = 1'b0;
         if (cs_enc_n !== mode || rsp_valid !== 1'b0) obs_wait_bad++;
         if (dec_u) begin
            miso_dec = res[127-j];
            miso_enc = 1'($urandom);
         end else begin
            miso_enc = res[127-j];
            miso_dec = 1'($urandom);
         end
      end
      @(negedge clk);
      miso_enc = 1'b0;
      miso_dec = 1'b0;
      obs_valid   = rsp_valid;
      obs_data    = rsp_data;
      obs_err     = rsp_err;
      obs_cs_resp = {cs_enc_n, cs_dec_n};
      for (int b = 0; b < bp; b++) begin
         @(negedge clk);
         if (rsp_valid !== 1'b1 || rsp_data !== obs_data ||
             rsp_err !== obs_err || req_ready !== 1'b0 ||
             busy !== 1'b1) obs_hold_bad++;
         req_valid = (b == bp / 2);
         req_key   = rand_key();
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      obs_post = {req_ready, rsp_valid, busy, cs_enc_n, cs_dec_n};
   endtask

   task automatic test_reset();
      rst = 1'b0;
      #2;
      n_cmp++;
      if ({req_ready, rsp_valid, rsp_err, busy, mosi, cs_enc_n, cs_dec_n}
          !== 7'b1000011) begin
         n_bad++;
         $display("FAIL reset_ctl got=%b want=1000011",
                  {req_ready, rsp_valid, rsp_err, busy, mosi,
                   cs_enc_n, cs_dec_n});
      end
      n_cmp++;
      if (rsp_data !== 128'h0) begin
         n_bad++;
         $display("FAIL reset_data got=%h want=0", rsp_data);
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      n_cmp++;
      if ({req_ready, busy, cs_enc_n, cs_dec_n} !== 4'b1011) begin
         n_bad++;
         $display("FAIL idle_after_reset got=%b want=1011",
                  {req_ready, busy, cs_enc_n, cs_dec_n});
      end
   endtask

   task automatic test_encrypt();
      run_txn(1'b0, KAT_KEY, KAT_PT, 5, 1'b1, 0);
      n_cmp++;
      if (obs_rdy_pre !== 1'b1) begin
         n_bad++;
         $display("FAIL enc_req_ready got=%b want=1", obs_rdy_pre);
      end
      n_cmp++;
      if (obs_cs_bad !== 0) begin
         n_bad++;
         $display("FAIL enc_cs_shift bad_cycles=%0d want=0", obs_cs_bad);
      end
      n_cmp++;
      if (obs_rx !== {KAT_KEY, KAT_PT}) begin
         n_bad++;
         $display("FAIL enc_mosi got=%h want=%h", obs_rx, {KAT_KEY, KAT_PT});
      end
      n_cmp++;
      if (obs_wait_bad !== 0) begin
         n_bad++;
         $display("FAIL enc_spurious_done bad_cycles=%0d want=0",
                  obs_wait_bad);
      end
      n_cmp++;
      if (obs_valid !== 1'b1 || obs_data !== KAT_CT || obs_err !== 1'b0)
      begin
         n_bad++;
         $display("FAIL enc_rsp got=%b/%h/%b want=1/%h/0",
                  obs_valid, obs_data, obs_err, KAT_CT);
      end
      n_cmp++;
      if (obs_cs_resp !== 2'b11) begin
         n_bad++;
         $display("FAIL enc_cs_resp got=%b want=11", obs_cs_resp);
      end
      n_cmp++;
      if (obs_post !== 5'b10011) begin
         n_bad++;
         $display("FAIL enc_post got=%b want=10011", obs_post);
      end
   endtask

   task automatic test_decrypt();
      run_txn(1'b1, KAT_KEY, KAT_CT, 3, 1'b0, 2);
      n_cmp++;
      if (obs_cs_bad !== 0) begin
         n_bad++;
         $display("FAIL dec_cs_shift bad_cycles=%0d want=0", obs_cs_bad);
      end
      n_cmp++;
      if (obs_rx !== {KAT_KEY, KAT_CT}) begin
         n_bad++;
         $display("FAIL dec_mosi got=%h want=%h", obs_rx, {KAT_KEY, KAT_CT});
      end
      n_cmp++;
      if (obs_valid !== 1'b1 || obs_data !== KAT_PT || obs_err !== 1'b0)
      begin
         n_bad++;
         $display("FAIL dec_rsp got=%b/%h/%b want=1/%h/0",
                  obs_valid, obs_data, obs_err, KAT_PT);
      end
      n_cmp++;
      if (obs_post !== 5'b10011) begin
         n_bad++;
         $display("FAIL dec_post got=%b want=10011", obs_post);
      end
   endtask

   task automatic test_backpressure();
      logic [255:0] k;
      logic [127:0] d;
      bit           m;
      k = rand_key();
      d = rand_blk();
      m = 1'($urandom);
      run_txn(m, k, d, 2, 1'b0, 50);
      n_cmp++;
      if (obs_valid !== 1'b1 || obs_data !== unit_fn(m, k, d)) begin
         n_bad++;
         $display("FAIL bp_rsp got=%b/%h want=1/%h",
                  obs_valid, obs_data, unit_fn(m, k, d));
      end
      n_cmp++;
      if (obs_hold_bad !== 0) begin
         n_bad++;
         $display("FAIL bp_hold bad_cycles=%0d want=0", obs_hold_bad);
      end
      n_cmp++;
      if (obs_post !== 5'b10011) begin
         n_bad++;
         $display("FAIL bp_post got=%b want=10011", obs_post);
      end
   endtask

   task automatic test_random();
      logic [255:0] k;
      logic [127:0] d;
      bit           m;
      for (int t = 0; t < 6; t++) begin
         k = rand_key();
         d = rand_blk();
         m = 1'($urandom);
         run_txn(m, k, d, $urandom_range(12, 1), 1'($urandom),
                 $urandom_range(3, 0));
         n_cmp++;
         if (obs_rx !== {k, d} || obs_cs_bad !== 0) begin
            n_bad++;
            $display("FAIL rnd%0d_shift got=%h cs_bad=%0d want=%h",
                     t, obs_rx, obs_cs_bad, {k, d});
         end
         n_cmp++;
         if (obs_data !== unit_fn(m, k, d) || obs_err !== 1'b0 ||
             obs_wait_bad !== 0) begin
            n_bad++;
            $display("FAIL rnd%0d_rsp got=%h/%b wb=%0d want=%h/0",
                     t, obs_data, obs_err, obs_wait_bad, unit_fn(m, k, d));
         end
         n_cmp++;
         if (obs_post !== 5'b10011 || obs_hold_bad !== 0) begin
            n_bad++;
            $display("FAIL rnd%0d_post got=%b hold=%0d want=10011",
                     t, obs_post, obs_hold_bad);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [255:0] k;
      logic [127:0] d;
      @(negedge clk);
      req_valid = 1'b1;
      req_mode  = 1'($urandom);
      req_key   = rand_key();
      req_data  = rand_blk();
      @(negedge clk);
      req_valid = 1'b0;
      repeat (300) @(negedge clk);
      rst = 1'b0;
      #1;
      n_cmp++;
      if ({cs_enc_n, cs_dec_n, busy, req_ready, rsp_valid} !== 5'b11010)
      begin
         n_bad++;
         $display("FAIL reset_mid got=%b want=11010",
                  {cs_enc_n, cs_dec_n, busy, req_ready, rsp_valid});
      end
      @(negedge clk);
      rst = 1'b1;
      k = rand_key();
      d = rand_blk();
      run_txn(1'b0, k, d, 4, 1'b0, 1);
      n_cmp++;
      if (obs_rx !== {k, d} || obs_data !== unit_fn(1'b0, k, d) ||
          obs_post !== 5'b10011) begin
         n_bad++;
         $display("FAIL after_reset_txn got=%h post=%b want=%h",
                  obs_data, obs_post, unit_fn(1'b0, k, d));
      end
   endtask

`ifdef AES_SEQ_TIMEOUT_EN
   task automatic test_timeout();
      int bad;
      bad = 0;
      @(negedge clk);
      req_valid = 1'b1;
      req_mode  = 1'($urandom);
      req_key   = rand_key();
      req_data  = rand_blk();
      @(negedge clk);
      req_valid = 1'b0;
      repeat (383) @(negedge clk);
      for (int w = 1; w <= TO; w++) begin
         @(negedge clk);
         if (rsp_valid !== 1'b0 || busy !== 1'b1) bad++;
      end
      n_cmp++;
      if (bad !== 0) begin
         n_bad++;
         $display("FAIL timeout_early bad_cycles=%0d want=0", bad);
      end
      @(negedge clk);
      n_cmp++;
      if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_data !== 128'h0 ||
          {cs_enc_n, cs_dec_n} !== 2'b11) begin
         n_bad++;
         $display("FAIL timeout_rsp got=%b/%b/%h/%b want=1/1/0/11",
                  rsp_valid, rsp_err, rsp_data, {cs_enc_n, cs_dec_n});
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      n_cmp++;
      if (req_ready !== 1'b1 || rsp_err !== 1'b0) begin
         n_bad++;
         $display("FAIL timeout_post got=%b/%b want=1/0", req_ready, rsp_err);
      end
   endtask
`else
   task automatic test_long_wait();
      logic [255:0] k;
      logic [127:0] d;
      k = rand_key();
      d = rand_blk();
      run_txn(1'b0, k, d, 10000, 1'b0, 0);
      n_cmp++;
      if (obs_wait_bad !== 0) begin
         n_bad++;
         $display("FAIL long_wait bad_cycles=%0d want=0", obs_wait_bad);
      end
      n_cmp++;
      if (obs_data !== unit_fn(1'b0, k, d) || obs_err !== 1'b0) begin
         n_bad++;
         $display("FAIL long_wait_rsp got=%h/%b want=%h/0",
                  obs_data, obs_err, unit_fn(1'b0, k, d));
      end
   endtask
`endif

   initial begin
      req_valid = 1'b0;
      req_mode  = 1'b0;
      req_key   = '0;
      req_data  = '0;
      rsp_ready = 1'b0;
      miso_enc  = 1'b0;
      miso_dec  = 1'b0;
      done_enc  = 1'b0;
      done_dec  = 1'b0;
      test_reset();
      test_encrypt();
      test_decrypt();
      test_backpressure();
      test_random();
      test_reset_mid();
`ifdef AES_SEQ_TIMEOUT_EN
      test_timeout();
`else
      test_long_wait();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
